// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the IF-stage PC/fetch block.
// The FSM state encoding is also exported on the top's debug port.
package pc_fetch_unit_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    localparam int RESET_VECTOR_DEFAULT = 0;
    localparam int COUNT_BITS           = 16;

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (v == {COUNT_BITS{1'b1}}) ? v : v + COUNT_BITS'(1);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_register.sv
// Pipeline register for one fetched instruction with load, hold and flush.
// Flush wins over load; with neither asserted every field holds.
module if_id_register #(
    parameter int DataWidth = 16,
    parameter int AddrBits  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] instr_i,
    input  logic [AddrBits-1:0]  pc_i,
    input  logic [AddrBits-1:0]  pc_plus_one_i,
    input  logic                 predicted_i,
    output logic [DataWidth-1:0] instr_o,
    output logic [AddrBits-1:0]  pc_o,
    output logic [AddrBits-1:0]  pc_plus_one_o,
    output logic                 predicted_o,
    output logic                 valid_o
);

    logic [DataWidth-1:0] instr_q;
    logic [AddrBits-1:0]  pc_q;
    logic [AddrBits-1:0]  pc_plus_one_q;
    logic                 predicted_q;
    logic                 valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q       <= '0;
            pc_q          <= '0;
            pc_plus_one_q <= '0;
            predicted_q   <= 1'b0;
            valid_q       <= 1'b0;
        end else if (flush_i) begin
            instr_q       <= '0;
            pc_q          <= '0;
            pc_plus_one_q <= '0;
            predicted_q   <= 1'b0;
            valid_q       <= 1'b0;
        end else if (load_i) begin
            instr_q       <= instr_i;
            pc_q          <= pc_i;
            pc_plus_one_q <= pc_plus_one_i;
            predicted_q   <= predicted_i;
            valid_q       <= 1'b1;
        end
    end

    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus_one_o = pc_plus_one_q;
    assign predicted_o   = predicted_q;
    assign valid_o       = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: PC register, next-PC selection (miss > stall > predicted > sequential),
// boot FSM, fetch/miss counters, and the IF/ID pipeline register.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                  DataWidth   = 16,
    parameter int                  AddrBits    = 16,
    parameter logic [AddrBits-1:0] ResetVector = AddrBits'(RESET_VECTOR_DEFAULT)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Stall,
    input  logic                  PredictionMiss,
    input  logic [AddrBits-1:0]   CorrectedAddress,
    input  logic                  TakeBranch,
    input  logic [AddrBits-1:0]   PredictedAddress,
    input  logic [DataWidth-1:0]  IMemData,
    output logic [AddrBits-1:0]   IMemAddr,
    output logic [DataWidth-1:0]  Instruction,
    output logic [AddrBits-1:0]   PCPlusOne,
    output logic [DataWidth-1:0]  IFID_Instruction,
    output logic [AddrBits-1:0]   IFID_PC,
    output logic [AddrBits-1:0]   IFID_PCPlusOne,
    output logic                  IFID_Predicted,
    output logic                  IFID_Valid,
    output logic [COUNT_BITS-1:0] FetchCount,
    output logic [COUNT_BITS-1:0] MissCount,
    output fetch_state_t          DbgState
);

    fetch_state_t          state_q, state_d;
    logic [AddrBits-1:0]   pc_q, pc_d;
    logic [COUNT_BITS-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [COUNT_BITS-1:0] miss_cnt_q, miss_cnt_d;
    logic                  ifid_load;
    logic                  ifid_flush;
    logic [AddrBits-1:0]   pc_plus_one;

    assign pc_plus_one = pc_q + AddrBits'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_BOOT;
            pc_q        <= ResetVector;
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        unique case (state_q)
            // Memory settle cycle: a miss here is deliberately ignored.
            ST_BOOT: begin
                state_d    = ST_RUN;
                ifid_flush = 1'b1;
            end
            ST_RUN: begin
                if (PredictionMiss) begin
                    pc_d       = CorrectedAddress;
                    ifid_flush = 1'b1;
                    miss_cnt_d = sat_inc(miss_cnt_q);
                end else if (!Stall) begin
                    pc_d        = TakeBranch ? PredictedAddress : pc_plus_one;
                    ifid_load   = 1'b1;
                    fetch_cnt_d = sat_inc(fetch_cnt_q);
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // IFID_Valid qualifies every IFID_* field: downstream may only consume them when it is 1.
    if_id_register #(
        .DataWidth (DataWidth),
        .AddrBits  (AddrBits)
    ) u_if_id (
        .clk_i         (CLK),
        .rst_ni        (RST),
        .load_i        (ifid_load),
        .flush_i       (ifid_flush),
        .instr_i       (IMemData),
        .pc_i          (pc_q),
        .pc_plus_one_i (pc_plus_one),
        .predicted_i   (TakeBranch),
        .instr_o       (IFID_Instruction),
        .pc_o          (IFID_PC),
        .pc_plus_one_o (IFID_PCPlusOne),
        .predicted_o   (IFID_Predicted),
        .valid_o       (IFID_Valid)
    );

    assign IMemAddr    = pc_q;
    assign Instruction = IMemData;
    assign PCPlusOne   = pc_plus_one;
    assign FetchCount  = fetch_cnt_q;
    assign MissCount   = miss_cnt_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a reference model of the fetch rules checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        CLK;
    logic        RST;
    logic        Stall;
    logic        PredictionMiss;
    logic [15:0] CorrectedAddress;
    logic        TakeBranch;
    logic [15:0] PredictedAddress;
    logic [15:0] IMemData;
    logic [15:0] IMemAddr;
    logic [15:0] Instruction;
    logic [15:0] PCPlusOne;
    logic [15:0] IFID_Instruction;
    logic [15:0] IFID_PC;
    logic [15:0] IFID_PCPlusOne;
    logic        IFID_Predicted;
    logic        IFID_Valid;
    logic [15:0] FetchCount;
    logic [15:0] MissCount;
    fetch_state_t DbgState;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit dut (
        .CLK              (CLK),
        .RST              (RST),
        .Stall            (Stall),
        .PredictionMiss   (PredictionMiss),
        .CorrectedAddress (CorrectedAddress),
        .TakeBranch       (TakeBranch),
        .PredictedAddress (PredictedAddress),
        .IMemData         (IMemData),
        .IMemAddr         (IMemAddr),
        .Instruction      (Instruction),
        .PCPlusOne        (PCPlusOne),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC          (IFID_PC),
        .IFID_PCPlusOne   (IFID_PCPlusOne),
        .IFID_Predicted   (IFID_Predicted),
        .IFID_Valid       (IFID_Valid),
        .FetchCount       (FetchCount),
        .MissCount        (MissCount),
        .DbgState         (DbgState)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory: deterministic content derived from the address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], ~a[15:8]} ^ 16'h5A3C;
    endfunction
    assign IMemData = mem_fn(IMemAddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record for the PC and one for the fetched instruction.
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc1;
        logic        pred;
        logic        valid;
    } fetch_rec_t;

    logic        m_boot;
    logic [15:0] m_pc;
    fetch_rec_t  m_ifid;
    int          m_fetches;
    int          m_misses;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_boot    <= 1'b1;
            m_pc      <= 16'h0000;
            m_ifid    <= '{16'h0, 16'h0, 16'h0, 1'b0, 1'b0};
            m_fetches <= 0;
            m_misses  <= 0;
        end else if (m_boot) begin
            m_boot       <= 1'b0;
            m_ifid.valid <= 1'b0;
        end else if (PredictionMiss) begin
            m_pc     <= CorrectedAddress;
            m_ifid   <= '{16'h0, 16'h0, 16'h0, 1'b0, 1'b0};
            m_misses <= (m_misses < 65535) ? m_misses + 1 : 65535;
        end else if (!Stall) begin
            m_ifid    <= '{mem_fn(m_pc), m_pc, 16'(m_pc + 16'd1), TakeBranch, 1'b1};
            m_pc      <= TakeBranch ? PredictedAddress : 16'(m_pc + 16'd1);
            m_fetches <= (m_fetches < 65535) ? m_fetches + 1 : 65535;
        end
    end

    // Scoreboard: every falling edge, all outputs against the model.
    always @(negedge CLK) begin
        chk("imem_addr",  IMemAddr, m_pc);
        chk("instr",      Instruction, mem_fn(m_pc));
        chk("pc_plus1",   PCPlusOne, 16'(m_pc + 16'd1));
        chk("ifid_instr", IFID_Instruction, m_ifid.instr);
        chk("ifid_pc",    IFID_PC, m_ifid.pc);
        chk("ifid_pc1",   IFID_PCPlusOne, m_ifid.pc1);
        chk("ifid_pred",  IFID_Predicted, m_ifid.pred);
        chk("ifid_valid", IFID_Valid, m_ifid.valid);
        chk("fetch_cnt",  FetchCount, 32'(m_fetches));
        chk("miss_cnt",   MissCount, 32'(m_misses));
        chk("state",      DbgState, m_boot ? ST_BOOT : ST_RUN);
    end

    // Driver tasks
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Stall = 0; PredictionMiss = 0; TakeBranch = 0;
        CorrectedAddress = 16'h0; PredictedAddress = 16'h0;
    endtask

    typedef struct {
        logic        stall;
        logic        take;
        logic        miss;
        logic [15:0] pred;
        logic [15:0] corr;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000},
        '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000},
        '{1'b1, 1'b1, 1'b0, 16'h2222, 16'h0000},
        '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200},
        '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0300},
        '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000},
        '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hABCD},
        '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000},
        '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000},
        '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}
    };

    initial begin
        RST = 1'b0;
        idle_inputs();
        repeat (3) cyc();
        chk("rst_addr",  IMemAddr, 16'h0000);
        chk("rst_valid", IFID_Valid, 1'b0);
        chk("rst_fcnt",  FetchCount, 16'h0000);
        chk("rst_state", DbgState, ST_BOOT);

        // 1: release reset, BOOT cycle then sequential fetch
        RST = 1'b1;
        cyc();
        chk("boot_addr",  IMemAddr, 16'h0000);
        chk("boot_valid", IFID_Valid, 1'b0);
        chk("boot_state", DbgState, ST_RUN);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("seq_ifid_pc", IFID_PC, 32'(i));
            chk("seq_valid",   IFID_Valid, 1'b1);
            chk("seq_fcnt",    FetchCount, 32'(i + 1));
            chk("seq_addr",    IMemAddr, 32'(i + 1));
        end

        // 2: predicted taken branch at PC=5
        TakeBranch = 1; PredictedAddress = 16'h0040;
        cyc();
        idle_inputs();
        chk("br_addr",    IMemAddr, 16'h0040);
        chk("br_ifid_pc", IFID_PC, 16'h0005);
        chk("br_pred",    IFID_Predicted, 1'b1);
        chk("br_pc1",     IFID_PCPlusOne, 16'h0006);
        chk("br_fcnt",    FetchCount, 16'd6);

        // 3: stall three cycles at PC=8
        TakeBranch = 1; PredictedAddress = 16'h0008;
        cyc();
        idle_inputs();
        Stall = 1;
        repeat (3) begin
            cyc();
            chk("st_addr",    IMemAddr, 16'h0008);
            chk("st_ifid_pc", IFID_PC, 16'h0040);
            chk("st_pc1",     IFID_PCPlusOne, 16'h0041);
            chk("st_fcnt",    FetchCount, 16'd7);
        end
        Stall = 0;
        cyc();
        chk("st_resume_pc",   IFID_PC, 16'h0008);
        chk("st_resume_addr", IMemAddr, 16'h0009);
        chk("st_resume_fcnt", FetchCount, 16'd8);

        // 4: miss overrides stall and taken branch
        PredictionMiss = 1; CorrectedAddress = 16'h0100;
        Stall = 1; TakeBranch = 1; PredictedAddress = 16'h0055;
        cyc();
        idle_inputs();
        chk("miss_addr",  IMemAddr, 16'h0100);
        chk("miss_valid", IFID_Valid, 1'b0);
        chk("miss_pc",    IFID_PC, 16'h0000);
        chk("miss_mcnt",  MissCount, 16'd1);
        chk("miss_fcnt",  FetchCount, 16'd8);
        cyc();
        chk("post_miss_pc",    IFID_PC, 16'h0100);
        chk("post_miss_valid", IFID_Valid, 1'b1);
        chk("post_miss_addr",  IMemAddr, 16'h0101);

        // 5: wrap from all-ones
        TakeBranch = 1; PredictedAddress = 16'hFFFF;
        cyc();
        idle_inputs();
        chk("wrap_addr", IMemAddr, 16'hFFFF);
        chk("wrap_pc1",  PCPlusOne, 16'h0000);
        cyc();
        chk("wrap_next",     IMemAddr, 16'h0000);
        chk("wrap_ifid_pc",  IFID_PC, 16'hFFFF);
        chk("wrap_ifid_pc1", IFID_PCPlusOne, 16'h0000);

        // Mixed directed vectors, checked by the scoreboard
        foreach (vecs[k]) begin
            Stall = vecs[k].stall; TakeBranch = vecs[k].take; PredictionMiss = vecs[k].miss;
            PredictedAddress = vecs[k].pred; CorrectedAddress = vecs[k].corr;
            cyc();
        end
        idle_inputs();

        // 6: asynchronous reset mid-cycle at PC=0x33
        TakeBranch = 1; PredictedAddress = 16'h0033;
        cyc();
        idle_inputs();
        chk("pre_rst_addr", IMemAddr, 16'h0033);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("arst_addr",  IMemAddr, 16'h0000);
        chk("arst_valid", IFID_Valid, 1'b0);
        chk("arst_fcnt",  FetchCount, 16'h0000);
        chk("arst_mcnt",  MissCount, 16'h0000);
        chk("arst_state", DbgState, ST_BOOT);
        cyc();
        RST = 1'b1;
        PredictionMiss = 1; CorrectedAddress = 16'h0077;
        cyc();
        idle_inputs();
        chk("boot_miss_addr",  IMemAddr, 16'h0000);
        chk("boot_miss_valid", IFID_Valid, 1'b0);
        chk("boot_miss_mcnt",  MissCount, 16'h0000);
        cyc();
        chk("reboot_ifid_pc", IFID_PC, 16'h0000);
        chk("reboot_valid",   IFID_Valid, 1'b1);
        chk("reboot_addr",    IMemAddr, 16'h0001);
        chk("reboot_fcnt",    FetchCount, 16'd1);
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
